// File: rtl/imm_pkg.sv
// ============================================================================
// Module      : imm_pkg
// Description : Shared immediate-format enumeration and RV opcode constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ZIMM  = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // funct3 values selecting the shift forms of OP-IMM / OP-IMM-32
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
// ============================================================================
// Module      : imm_decode
// Description : Combinational RV32/RV64 immediate extractor and format classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_type_e       o_type,
    output logic            o_illegal
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic        w_sign;
    logic        w_shift;
    logic [31:0] w_imm32;

    assign w_opc   = i_instr[6:0];
    assign w_f3    = i_instr[14:12];
    assign w_sign  = i_instr[31];
    assign w_shift = (w_f3 == F3_SLL) || (w_f3 == F3_SRX);

    always_comb begin
        w_imm32   = '0;
        o_type    = IMM_NONE;
        o_illegal = 1'b0;
        case (w_opc)
            OPC_LOAD, OPC_JALR: begin
                o_type  = IMM_I;
                w_imm32 = {{20{w_sign}}, i_instr[31:20]};
            end
            OPC_OP_IMM: begin
                if (w_shift) begin
                    o_type = IMM_SHAMT;
                    if (XLEN == 64) begin
                        w_imm32 = {26'b0, i_instr[25:20]};
                    end else begin
                        w_imm32   = {27'b0, i_instr[24:20]};
                        o_illegal = i_instr[25];
                    end
                end else begin
                    o_type  = IMM_I;
                    w_imm32 = {{20{w_sign}}, i_instr[31:20]};
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 32) begin
                    o_illegal = 1'b1;
                end else if (w_shift) begin
                    o_type    = IMM_SHAMT;
                    w_imm32   = {27'b0, i_instr[24:20]};
                    o_illegal = i_instr[25];
                end else begin
                    o_type  = IMM_I;
                    w_imm32 = {{20{w_sign}}, i_instr[31:20]};
                end
            end
            OPC_STORE: begin
                o_type  = IMM_S;
                w_imm32 = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
            end
            OPC_BRANCH: begin
                o_type  = IMM_B;
                w_imm32 = {{19{w_sign}}, i_instr[31], i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                o_type  = IMM_U;
                w_imm32 = {i_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                o_type  = IMM_J;
                w_imm32 = {{11{w_sign}}, i_instr[31], i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                if (w_f3[2]) begin
                    o_type  = IMM_ZIMM;
                    w_imm32 = {27'b0, i_instr[19:15]};
                end else begin
                    o_type  = IMM_I;
                    w_imm32 = {{20{w_sign}}, i_instr[31:20]};
                end
            end
            OPC_OP: begin
                o_type = IMM_NONE;
            end
            OPC_OP_32: begin
                o_illegal = (XLEN == 32);
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

    // Zero-extended formats keep bit 31 clear, so one sign-extension covers every format.
    assign o_imm = XLEN'($signed(w_imm32));

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module      : imm_gen_pipe
// Description : Immediate decoder followed by a 2-entry skid buffer with registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_type_e        itype;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } imm_entry_t;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [XLEN-1:0] w_dec_imm;
    imm_type_e       w_dec_type;
    logic            w_dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .i_instr   (in_instr),
        .o_imm     (w_dec_imm),
        .o_type    (w_dec_type),
        .o_illegal (w_dec_illegal)
    );

    imm_entry_t r_e0, r_e1;
    logic       r_v0, r_v1, r_rdy;
    imm_entry_t w_new, w_e0_nxt, w_e1_nxt;
    logic       w_v0_nxt, w_v1_nxt, w_push, w_pop;

    assign w_new  = '{imm: w_dec_imm, itype: w_dec_type, illegal: w_dec_illegal, tag: in_tag};
    assign w_push = in_valid && r_rdy;
    assign w_pop  = r_v0 && out_ready;

    // Pop is resolved first; the push then lands in whichever entry is free afterwards.
    always_comb begin
        w_e0_nxt = r_e0;
        w_e1_nxt = r_e1;
        w_v0_nxt = r_v0;
        w_v1_nxt = r_v1;
        if (w_pop) begin
            if (r_v1) begin
                w_e0_nxt = r_e1;
                w_v1_nxt = 1'b0;
            end else begin
                w_v0_nxt = 1'b0;
            end
        end
        if (w_push) begin
            if (!w_v0_nxt) begin
                w_e0_nxt = w_new;
                w_v0_nxt = 1'b1;
            end else begin
                w_e1_nxt = w_new;
                w_v1_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e0  <= '0;
            r_e1  <= '0;
            r_v0  <= 1'b0;
            r_v1  <= 1'b0;
            r_rdy <= 1'b1;
        end else if (flush) begin
            r_v0  <= 1'b0;
            r_v1  <= 1'b0;
            r_rdy <= 1'b1;
        end else begin
            r_e0  <= w_e0_nxt;
            r_e1  <= w_e1_nxt;
            r_v0  <= w_v0_nxt;
            r_v1  <= w_v1_nxt;
            r_rdy <= !w_v1_nxt;
        end
    end

    assign in_ready    = r_rdy;
    assign out_valid   = r_v0;
    assign out_imm     = r_e0.imm;
    assign out_type    = r_e0.itype;
    assign out_illegal = r_e0.illegal;
    assign out_tag     = r_e0.tag;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Scoreboard bench driving an XLEN=32 and an XLEN=64 instance in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [4:0]  in_tag;

    logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  ty32, ty64;
    logic [4:0]  tag32, tag64;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] imm32;
        logic [2:0]  ty32;
        logic        ill32;
        bit          full32;
        logic [63:0] imm64;
        logic [2:0]  ty64;
        logic        ill64;
        logic [4:0]  tag;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic [4:0] next_tag = 5'd1;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
        .out_imm(imm32), .out_type(ty32), .out_illegal(ill32), .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
        .out_imm(imm64), .out_type(ty64), .out_illegal(ill64), .out_tag(tag64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: pop/compare on output transfers, push on input transfers, stall stability.
    bit          stalled = 1'b0;
    logic [31:0] s_imm32;
    logic [63:0] s_imm64;
    logic [4:0]  s_tag;
    always @(negedge clk) begin
        if (rst || flush) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            chk("valid_match", {63'b0, vld64}, {63'b0, vld32});
            if (vld32 && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {59'b0, tag32}, 64'h0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.full32) begin
                        chk("imm32", {32'b0, imm32}, {32'b0, e.imm32});
                        chk("type32", {61'b0, ty32}, {61'b0, e.ty32});
                    end
                    chk("ill32", {63'b0, ill32}, {63'b0, e.ill32});
                    chk("imm64", imm64, e.imm64);
                    chk("type64", {61'b0, ty64}, {61'b0, e.ty64});
                    chk("ill64", {63'b0, ill64}, {63'b0, e.ill64});
                    chk("tag32", {59'b0, tag32}, {59'b0, e.tag});
                    chk("tag64", {59'b0, tag64}, {59'b0, e.tag});
                end
            end
            if (vld32 && !out_ready) begin
                if (stalled) begin
                    chk("stall_imm32", {32'b0, imm32}, {32'b0, s_imm32});
                    chk("stall_imm64", imm64, s_imm64);
                    chk("stall_tag", {59'b0, tag32}, {59'b0, s_tag});
                end
                s_imm32 = imm32;
                s_imm64 = imm64;
                s_tag   = tag32;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (in_valid && rdy32) q.push_back(cur);
        end
    end

    task automatic drive(input logic [31:0] instr,
                         input logic [31:0] e_imm32, input logic [2:0] e_ty32,
                         input logic e_ill32, input bit e_full32,
                         input logic [63:0] e_imm64, input logic [2:0] e_ty64,
                         input logic e_ill64);
        cur.imm32  = e_imm32;
        cur.ty32   = e_ty32;
        cur.ill32  = e_ill32;
        cur.full32 = e_full32;
        cur.imm64  = e_imm64;
        cur.ty64   = e_ty64;
        cur.ill64  = e_ill64;
        cur.tag    = next_tag;
        in_instr   = instr;
        in_tag     = next_tag;
        in_valid   = 1'b1;
        next_tag   = next_tag + 5'd1;
    endtask

    task automatic wait_accept();
        bit acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = rdy32;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 64'h0, 64'h1);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] instr,
                        input logic [31:0] e_imm32, input logic [2:0] e_ty32,
                        input logic e_ill32, input bit e_full32,
                        input logic [63:0] e_imm64, input logic [2:0] e_ty64,
                        input logic e_ill64);
        drive(instr, e_imm32, e_ty32, e_ill32, e_full32, e_imm64, e_ty64, e_ill64);
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'h0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {63'b0, vld32}, 64'h0);
        chk("rst_ready", {63'b0, rdy32}, 64'h1);
        chk("rst_imm64", imm64, 64'h0);
        chk("rst_type", {61'b0, ty32}, 64'h0);
        @(posedge clk); #1;

        // Directed formats, back-to-back at full throughput
        send(32'hFFF00093, 32'hFFFFFFFF, IMM_I, 0, 1, 64'hFFFFFFFFFFFFFFFF, IMM_I, 0);
        send(32'hFE000EE3, 32'hFFFFFFFC, IMM_B, 0, 1, 64'hFFFFFFFFFFFFFFFC, IMM_B, 0);
        send(32'h800000B7, 32'h80000000, IMM_U, 0, 1, 64'hFFFFFFFF80000000, IMM_U, 0);
        send(32'h03F09093, 32'h0, IMM_SHAMT, 1, 0, 64'd63, IMM_SHAMT, 0);
        send(32'h0000007F, 32'h0, IMM_NONE, 1, 1, 64'h0, IMM_NONE, 1);
        send(32'hFE112E23, 32'hFFFFFFFC, IMM_S, 0, 1, 64'hFFFFFFFFFFFFFFFC, IMM_S, 0);
        send(32'hFFDFF0EF, 32'hFFFFFFFC, IMM_J, 0, 1, 64'hFFFFFFFFFFFFFFFC, IMM_J, 0);
        send(32'h3402D073, 32'd5, IMM_ZIMM, 0, 1, 64'd5, IMM_ZIMM, 0);
        send(32'h002081B3, 32'h0, IMM_NONE, 0, 1, 64'h0, IMM_NONE, 0);
        send(32'hFFF0809B, 32'h0, IMM_NONE, 1, 0, 64'hFFFFFFFFFFFFFFFF, IMM_I, 0);
        send(32'h0010909B, 32'h0, IMM_NONE, 1, 0, 64'd1, IMM_SHAMT, 0);
        send(32'h41F0D093, 32'd31, IMM_SHAMT, 0, 1, 64'd31, IMM_SHAMT, 0);
        send(32'h00001017, 32'h00001000, IMM_U, 0, 1, 64'h1000, IMM_U, 0);
        drain();

        // Backpressure: A and B fill the skid, C waits until the consumer resumes
        out_ready = 1'b0;
        send(32'h00100093, 32'd1, IMM_I, 0, 1, 64'd1, IMM_I, 0);
        send(32'h00200093, 32'd2, IMM_I, 0, 1, 64'd2, IMM_I, 0);
        drive(32'h00300093, 32'd3, IMM_I, 0, 1, 64'd3, IMM_I, 0);
        @(negedge clk);
        chk("full_ready", {63'b0, rdy32}, 64'h0);
        chk("full_valid", {63'b0, vld32}, 64'h1);
        chk("head_is_A", {32'b0, imm32}, 64'd1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_accept();
        drain();

        // Flush with both entries full and a new word offered
        out_ready = 1'b0;
        send(32'h00400093, 32'd4, IMM_I, 0, 1, 64'd4, IMM_I, 0);
        send(32'h00500093, 32'd5, IMM_I, 0, 1, 64'd5, IMM_I, 0);
        drive(32'h00600093, 32'd6, IMM_I, 0, 1, 64'd6, IMM_I, 0);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", {63'b0, vld32}, 64'h0);
        chk("flush_ready", {63'b0, rdy32}, 64'h1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Reset while one entry is held
        out_ready = 1'b0;
        send(32'hFFF00093, 32'hFFFFFFFF, IMM_I, 0, 1, 64'hFFFFFFFFFFFFFFFF, IMM_I, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst2_valid", {63'b0, vld32}, 64'h0);
        chk("rst2_ready", {63'b0, rdy32}, 64'h1);
        chk("rst2_imm32", {32'b0, imm32}, 64'h0);
        chk("rst2_imm64", imm64, 64'h0);
        chk("rst2_type", {61'b0, ty64}, 64'h0);
        chk("rst2_ill", {63'b0, ill32}, 64'h0);
        chk("rst2_tag", {59'b0, tag32}, 64'h0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h00A00513, 32'd10, IMM_I, 0, 1, 64'd10, IMM_I, 0);
        drain();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
